// File: rtl/memory_arbiter.sv
// Arbitrates the single RAM port between the instruction and data miss paths.
// Data wins by default; a streak counter forces an instruction grant after MAX_DSTREAK data grants.
module memory_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MAX_DSTREAK = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic [DATA_W-1:0] iload,
    output logic              iwait,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic [DATA_W-1:0] dload,
    output logic              dwait,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic [1:0]        ramstate
);

    localparam int SW = (MAX_DSTREAK < 2) ? 1 : $clog2(MAX_DSTREAK + 1);
    localparam logic [SW-1:0] DSTREAK_MAX = SW'(MAX_DSTREAK);

    typedef enum logic [1:0] {IDLE, IGNT, DGNT} state_t;

    state_t        state, state_nxt;
    logic [SW-1:0] dstreak;
    logic          d_req;
    logic          done;
    logic          i_aged;

    // ACCESS (10) and ERROR (11) both end the transaction.
    assign done   = ramstate[1];
    assign d_req  = dREN | dWEN;
    assign i_aged = iREN && (MAX_DSTREAK != 0) && (dstreak == DSTREAK_MAX);

    assign iload = ramload;
    assign dload = ramload;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            dstreak <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && state_nxt == IGNT) begin
                dstreak <= '0;
            end else if (state == DGNT && d_req && done) begin
                if (!iREN)
                    dstreak <= '0;
                else if (dstreak != DSTREAK_MAX)
                    dstreak <= dstreak + SW'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        ramREN    = 1'b0;
        ramWEN    = 1'b0;
        ramaddr   = '0;
        ramstore  = '0;
        iwait     = 1'b1;
        dwait     = 1'b1;
        case (state)
            IDLE: begin
                if (d_req && !i_aged)
                    state_nxt = DGNT;
                else if (iREN)
                    state_nxt = IGNT;
            end
            IGNT: begin
                ramaddr = iaddr;
                // A withdrawn request (flush) drops the strobe without a wait-low pulse.
                if (!iREN) begin
                    state_nxt = IDLE;
                end else begin
                    ramREN = 1'b1;
                    if (done) begin
                        iwait     = 1'b0;
                        state_nxt = IDLE;
                    end
                end
            end
            DGNT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                if (!d_req) begin
                    state_nxt = IDLE;
                end else begin
                    ramWEN = dWEN;
                    ramREN = dREN & ~dWEN;
                    if (done) begin
                        dwait     = 1'b0;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Randomized bench for memory_arbiter against a grant-level reference model,
// plus directed reset, priority/aging and reset-during-grant scenarios.
module tb_memory_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXD = 2;

    logic          CLK = 1'b0;
    logic          RST;
    logic          iREN, dREN, dWEN;
    logic [AW-1:0] iaddr, daddr;
    logic [DW-1:0] dstore, ramload;
    logic [DW-1:0] iload, dload, ramstore;
    logic [AW-1:0] ramaddr;
    logic          iwait, dwait, ramREN, ramWEN;
    logic [1:0]    ramstate;

    memory_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_DSTREAK(MAXD)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: who currently owns the RAM (0 none, 1 instr, 2 data) and the data streak.
    int m_owner  = 0;
    int m_streak = 0;

    logic log_en = 1'b0;
    logic [5:0] gnt_log;
    int n_log;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic done;
        logic e_ren, e_wen, e_iw, e_dw;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_store;
        done    = (ramstate == 2'b10) || (ramstate == 2'b11);
        e_ren   = 1'b0;
        e_wen   = 1'b0;
        e_addr  = '0;
        e_store = '0;
        if (m_owner == 1) begin
            e_ren  = iREN;
            e_addr = iaddr;
        end else if (m_owner == 2) begin
            e_wen   = dWEN;
            e_ren   = dREN && !dWEN;
            e_addr  = daddr;
            e_store = dstore;
        end
        e_iw = !(m_owner == 1 && iREN && done);
        e_dw = !(m_owner == 2 && (dREN || dWEN) && done);
        chk("ramREN", 64'(ramREN), 64'(e_ren));
        chk("ramWEN", 64'(ramWEN), 64'(e_wen));
        chk("ramaddr", 64'(ramaddr), 64'(e_addr));
        chk("ramstore", 64'(ramstore), 64'(e_store));
        chk("iwait", 64'(iwait), 64'(e_iw));
        chk("dwait", 64'(dwait), 64'(e_dw));
        chk("iload", 64'(iload), 64'(ramload));
        chk("dload", 64'(dload), 64'(ramload));
        if (log_en && (ramREN || ramWEN) && n_log < 6) begin
            gnt_log = {gnt_log[4:0], (ramaddr == 32'h40)};
            n_log++;
        end
    endtask

    task automatic model_edge();
        logic done;
        done = (ramstate == 2'b10) || (ramstate == 2'b11);
        if (m_owner == 0) begin
            if ((dREN || dWEN) && !(iREN && MAXD != 0 && m_streak >= MAXD)) begin
                m_owner = 2;
            end else if (iREN) begin
                m_owner  = 1;
                m_streak = 0;
            end
        end else if (m_owner == 1) begin
            if (!iREN || done) m_owner = 0;
        end else begin
            if (!(dREN || dWEN)) begin
                m_owner = 0;
            end else if (done) begin
                m_streak = iREN ? ((m_streak + 1 > MAXD) ? MAXD : m_streak + 1) : 0;
                m_owner  = 0;
            end
        end
    endtask

    // Called just after a rising edge: drive, check mid-cycle, advance the model on the next edge.
    task automatic step(input logic ir, input logic dr, input logic dw, input logic [1:0] rs);
        iREN     = ir;
        dREN     = dr;
        dWEN     = dw;
        ramstate = rs;
        ramload  = $urandom;
        dstore   = $urandom;
        @(negedge CLK);
        check_outputs();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    initial begin
        RST = 1'b1;
        iREN = 1'b1; dREN = 1'b1; dWEN = 1'b1;
        iaddr = 32'h40; daddr = 32'h100; dstore = 32'h5;
        ramload = '0; ramstate = 2'b10;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_ramREN", 64'(ramREN), 64'd0);
        chk("rst_ramWEN", 64'(ramWEN), 64'd0);
        chk("rst_ramaddr", 64'(ramaddr), 64'd0);
        chk("rst_ramstore", 64'(ramstore), 64'd0);
        chk("rst_iwait", 64'(iwait), 64'd1);
        chk("rst_dwait", 64'(dwait), 64'd1);
        @(posedge CLK);
        #1 RST = 1'b0;

        // Released with all requests high: data granted after the next edge.
        step(1, 0, 1, 2'b01);
        chk("first_gnt_wen", 64'(ramWEN), 64'd1);
        step(1, 0, 1, 2'b10);
        step(1, 0, 0, 2'b00);
        step(1, 0, 0, 2'b01);
        step(1, 0, 0, 2'b01);
        ramload = 32'hDEADBEEF;
        iREN = 1'b1; ramstate = 2'b10;
        @(negedge CLK);
        check_outputs();
        chk("iload_beef", 64'(iload), 64'hDEADBEEF);
        @(posedge CLK);
        model_edge();
        #1;
        step(0, 0, 0, 2'b00);
        step(0, 0, 0, 2'b00);

        // Aging: with both held and instant completion the order is D,D,I repeating.
        m_streak = 0;
        RST = 1'b1;
        #1 RST = 1'b0;
        m_owner = 0;
        log_en = 1'b1; n_log = 0; gnt_log = '0;
        repeat (14) step(1, 1, 0, 2'b10);
        log_en = 1'b0;
        chk("grant_order", 64'(gnt_log), 64'(6'b001001));
        step(0, 0, 0, 2'b00);
        step(0, 0, 0, 2'b00);

        // Withdrawal mid-BUSY then pending data; ERROR completion.
        step(1, 0, 0, 2'b01);
        step(1, 0, 0, 2'b01);
        step(0, 1, 0, 2'b01);
        step(0, 1, 0, 2'b01);
        step(0, 1, 0, 2'b11);
        step(0, 0, 0, 2'b00);

        // Random traffic.
        for (int n = 0; n < 1500; n++) begin
            iaddr = $urandom;
            daddr = $urandom;
            step(($urandom % 4) != 0, ($urandom % 3) == 0, ($urandom % 3) == 0, 2'($urandom));
        end

        // Reset asserted during a data grant drops the strobes immediately.
        step(0, 0, 0, 2'b00);
        step(0, 0, 0, 2'b00);
        step(0, 0, 1, 2'b01);
        dWEN = 1'b1; ramstate = 2'b01;
        #2;
        chk("dgnt_wen", 64'(ramWEN), 64'd1);
        RST = 1'b1;
        #1;
        chk("arst_wen", 64'(ramWEN), 64'd0);
        chk("arst_ren", 64'(ramREN), 64'd0);
        chk("arst_dwait", 64'(dwait), 64'd1);
        m_owner = 0; m_streak = 0;
        @(posedge CLK);
        #1 RST = 1'b0;
        step(0, 0, 0, 2'b00);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
